// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding the CP0 HWInt vector.
//
// Latches up to NSRC device irq lines. Each source is in level mode (pending
// follows the line) or edge mode (a rising edge sets pending; software clears
// it with write-1-to-clear). A software mask gates pending onto hw_int.
//
// Register window, at byte offsets from BASE:
//   0x00 PENDING  R, W1C (W1C only acts on edge-mode bits)
//   0x04 MASK     RW, 1 = enabled
//   0x08 MODE     RW, 0 = level, 1 = edge
//   0x0C RAW      R, current src_irq
//   0x10 ID       R, 1 + index of lowest set hw_int bit, 0 if none.
//                 Built only when IRQ_CTRL_ID_EN is defined; otherwise reads 0.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          synchronous active-low reset
//   addr         full bus byte address
//   write_enable bus write strobe
//   write_data   bus write data
//   read_result  combinational read data for addr
//   src_irq      device interrupt lines, synchronous to clk
//   hw_int       masked pending vector to CP0, bits >= NSRC are 0
//   irq          OR of hw_int
module irq_ctrl #(
    parameter logic [31:0] BASE = 32'h0000_7f20,
    parameter int          NSRC = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            write_enable,
    input  logic [31:0]     write_data,
    output logic [31:0]     read_result,
    input  logic [NSRC-1:0] src_irq,
    output logic [5:0]      hw_int,
    output logic            irq
);

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] src_d_q, src_d_d;

    logic [31:0]     off;
    logic            wr_pend, wr_mask, wr_mode;
    logic [NSRC-1:0] wdata;
    logic [NSRC-1:0] rise, clr, mode_chg;
    logic [NSRC-1:0] hw_vec;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^write_data[31:NSRC];

    assign off     = addr - BASE;
    assign wdata   = write_data[NSRC-1:0];
    assign wr_pend = write_enable && (off == 32'h0);
    assign wr_mask = write_enable && (off == 32'h4);
    assign wr_mode = write_enable && (off == 32'h8);

    assign rise     = src_irq & ~src_d_q;
    assign clr      = wr_pend ? wdata : '0;
    // A bit switching mode drops whatever it held under the old mode.
    assign mode_chg = wr_mode ? (wdata ^ mode_q) : '0;

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_chg[i])
                pending_d[i] = 1'b0;
            else if (mode_q[i])
                // Set beats clear when both land on the same cycle.
                pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
            else
                pending_d[i] = src_irq[i];
        end
    end

    always_comb begin
        mask_d  = wr_mask ? wdata : mask_q;
        mode_d  = wr_mode ? wdata : mode_q;
        src_d_d = src_irq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            src_d_q   <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            src_d_q   <= src_d_d;
        end
    end

    assign hw_vec = pending_q & mask_q;

    always_comb begin
        hw_int = '0;
        hw_int[NSRC-1:0] = hw_vec;
    end

    assign irq = |hw_vec;

`ifdef IRQ_CTRL_ID_EN
    logic [31:0] id;
    // Scan downwards so the lowest-numbered set bit is the last to win.
    always_comb begin
        id = 32'h0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hw_vec[i])
                id = 32'(i + 1);
        end
    end
`else
    logic [31:0] id;
    assign id = 32'h0;
`endif

    always_comb begin
        read_result = 32'h0;
        case (off)
            32'h00:  read_result[NSRC-1:0] = pending_q;
            32'h04:  read_result[NSRC-1:0] = mask_q;
            32'h08:  read_result[NSRC-1:0] = mode_q;
            32'h0C:  read_result[NSRC-1:0] = src_irq;
            32'h10:  read_result = id;
            default: read_result = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_7f20;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_MASK = BASE + 32'h04;
    localparam logic [31:0] A_MODE = BASE + 32'h08;
    localparam logic [31:0] A_RAW  = BASE + 32'h0C;
    localparam logic [31:0] A_ID   = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_result;
    logic [5:0]  src_irq;
    logic [5:0]  hw_int;
    logic        irq;

    int nvec = 0;
    int nmis = 0;

    irq_ctrl #(.BASE(BASE), .NSRC(6)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .write_data(write_data), .read_result(read_result),
        .src_irq(src_irq), .hw_int(hw_int), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = read_result;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        write_data = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        write_data = 32'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        rst = 1'b0;
        addr = 32'h0;
        write_enable = 1'b0;
        write_data = 32'h0;
        src_irq = 6'h0;
        step();
        step();
        rst = 1'b1;

        // 1: reset state; level mode with mask 0 keeps hw_int quiet
        chk_rd("rst_pend", A_PEND, 32'h0);
        chk_rd("rst_mask", A_MASK, 32'h0);
        chk_rd("rst_mode", A_MODE, 32'h0);
        chk("rst_hw", {26'h0, hw_int}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        src_irq = 6'h3F;
        step();
        chk_rd("lvl_all_pend", A_PEND, 32'h3F);
        chk_rd("raw_all", A_RAW, 32'h3F);
        chk("lvl_all_hw", {26'h0, hw_int}, 32'h0);
        chk("lvl_all_irq", {31'h0, irq}, 32'h0);
        src_irq = 6'h0;
        step();

        // 2: level mode, one-cycle latency, W1C ignored
        wr(A_MASK, 32'h1);
        src_irq = 6'h01;
        chk("lvl_lat0", {26'h0, hw_int}, 32'h0);
        step(); chk("lvl_c1", {26'h0, hw_int}, 32'h1);
        step(); chk("lvl_c2", {26'h0, hw_int}, 32'h1);
        step(); chk("lvl_c3", {26'h0, hw_int}, 32'h1);
        src_irq = 6'h0;
        chk("lvl_c3_irq", {31'h0, irq}, 32'h1);
        step(); chk("lvl_drop", {26'h0, hw_int}, 32'h0);
        src_irq = 6'h01;
        step();
        wr(A_PEND, 32'h1);
        chk_rd("lvl_w1c_ign", A_PEND, 32'h1);
        src_irq = 6'h0;
        step();
        chk_rd("lvl_fall", A_PEND, 32'h0);

        // 3: edge mode captures a one-cycle pulse until W1C
        wr(A_MODE, 32'h1);
        src_irq = 6'h01;
        step();
        src_irq = 6'h0;
        step();
        chk_rd("edge_pend", A_PEND, 32'h1);
        chk("edge_hw", {26'h0, hw_int}, 32'h1);
        step();
        chk("edge_hold", {26'h0, hw_int}, 32'h1);
        wr(A_PEND, 32'h1);
        chk_rd("edge_clr", A_PEND, 32'h0);
        chk("edge_clr_irq", {31'h0, irq}, 32'h0);

        // 4: rising edge coincident with W1C on the same bit: set wins
        wr(A_MODE, 32'h5);
        addr = A_PEND;
        write_data = 32'h4;
        write_enable = 1'b1;
        src_irq = 6'h04;
        #1;
        chk("pend_no_same_cyc", read_result, 32'h0);
        step();
        write_enable = 1'b0;
        write_data = 32'h0;
        src_irq = 6'h0;
        chk_rd("set_wins", A_PEND, 32'h4);
        wr(A_PEND, 32'h4);
        chk_rd("set_wins_clr", A_PEND, 32'h0);

        // 5: masked edge stays latched, unmask exposes it, mode change clears
        wr(A_MASK, 32'h0);
        wr(A_MODE, 32'h2);
        src_irq = 6'h02;
        step();
        src_irq = 6'h0;
        step();
        chk_rd("msk_pend", A_PEND, 32'h2);
        chk("msk_hw", {26'h0, hw_int}, 32'h0);
        chk("msk_irq", {31'h0, irq}, 32'h0);
        wr(A_MASK, 32'h2);
        chk("unmsk_hw", {26'h0, hw_int}, 32'h2);
        chk("unmsk_irq", {31'h0, irq}, 32'h1);
        wr(A_MODE, 32'h0);
        chk_rd("modechg_pend", A_PEND, 32'h0);
        chk("modechg_hw", {26'h0, hw_int}, 32'h0);

        // Window edges and unimplemented bits
        wr(A_MASK, 32'hFFFF_FFFF);
        chk_rd("mask_wide", A_MASK, 32'h3F);
        wr(BASE - 32'h4, 32'h0);
        wr(A_RAW, 32'h0);
        wr(BASE + 32'h14, 32'h0);
        chk_rd("oow_nowrite", A_MASK, 32'h3F);
        chk_rd("oow_read", BASE + 32'h14, 32'h0);

        // 6: ID priority encoder and reset dominance
        wr(A_MODE, 32'h3F);
        src_irq = 6'h28;
        step();
        src_irq = 6'h0;
        step();
        chk_rd("id_pend", A_PEND, 32'h28);
`ifdef IRQ_CTRL_ID_EN
        chk_rd("id_4", A_ID, 32'h4);
`else
        chk_rd("id_off", A_ID, 32'h0);
`endif
        wr(A_PEND, 32'h8);
        chk_rd("id_pend2", A_PEND, 32'h20);
`ifdef IRQ_CTRL_ID_EN
        chk_rd("id_6", A_ID, 32'h6);
`else
        chk_rd("id_off2", A_ID, 32'h0);
`endif
        wr(A_ID, 32'hFF);
        wr(A_PEND, 32'h3F);
        chk_rd("id_none", A_ID, 32'h0);
        src_irq = 6'h28;
        step();
        src_irq = 6'h0;
        step();
        chk("pre_rst_hw", {26'h0, hw_int}, 32'h28);
        rst = 1'b0;
        addr = A_MASK;
        write_data = 32'h15;
        write_enable = 1'b1;
        src_irq = 6'h01;
        step();
        rst = 1'b1;
        write_enable = 1'b0;
        write_data = 32'h0;
        src_irq = 6'h0;
        chk_rd("mid_rst_pend", A_PEND, 32'h0);
        chk_rd("mid_rst_mask", A_MASK, 32'h0);
        chk_rd("mid_rst_mode", A_MODE, 32'h0);
        chk("mid_rst_hw", {26'h0, hw_int}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller sitting directly downstream of the timers and other bus devices. Collects up to NSRC device irq lines and latches them per source, in level or edge mode. Applies a software mask and drives the hardware interrupt vector consumed by CP0 (HWInt). Edge mode captures one-cycle pulses, such as those a periodic timer emits, that CP0 could otherwise miss.

Parameters:
BASE, 32'h00007f20, byte address of register 0; window is BASE..BASE+0x13
NSRC, 6, number of interrupt sources (1..6); unused upper bits read 0

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-low reset: rst==0 at a posedge resets all state
addr  input  32  bus byte address (full address, not offset)
write_enable  input  1  bus write strobe
write_data  input  32  bus write data
read_result  output  32  combinational read data for addr
src_irq  input  NSRC  device interrupt lines, synchronous to clk
hw_int  output  6  per-source masked pending vector to CP0; bits >= NSRC tied 0
irq  output  1  OR of hw_int

Behaviour:
- Offset: off = addr - BASE (unsigned). write_valid = write_enable && off in {0,4,8}. Other offsets: writes ignored, reads return 0.
- Register map:
  - 0x0 PENDING: R; W1C, effective on edge-mode bits only.
  - 0x4 MASK: RW, 1 = enabled.
  - 0x8 MODE: RW, 0 = level, 1 = edge.
  - 0xC RAW: R, current src_irq.
  - 0x10: reserved, or ID under the optional feature.
- Reset (rst==0): pending=0, mask=0, mode=0, src_d=0. hw_int=0 and irq=0 from the first cycle after reset.
- src_d is a register holding the previous-cycle src_irq. rise = src_irq & ~src_d.
- Per-bit pending update each posedge, with rst==1:
  - Level bit: pending <= src_irq[i]. W1C writes are ignored.
  - Edge bit: pending <= rise[i] | (pending[i] & ~clr[i]). clr = write_data bits when writing PENDING. A set on the same cycle as a clear wins (stays 1).
- MODE write: any bit whose mode changes has its pending forced to 0 that cycle. It follows the new mode from the next cycle. src_d still updates normally.
- MASK write takes effect on the next cycle's hw_int. Mask does not gate pending capture: a masked edge stays latched and appears on hw_int when unmasked.
- hw_int = pending & mask (combinational from registers), so src_irq to hw_int latency is exactly 1 clock. irq = |hw_int.
- src_d resets to 0, so a source already high on the first cycle after reset is seen as a rising edge in edge mode.
- Reset mid-operation dominates any write or edge on the same posedge.
- read_result is purely combinational (no read strobe, no read side effects). PENDING reads return the register value, not including an edge arriving in the same cycle.
- Write data bits >= NSRC are ignored; those register bits read 0.
- No internal FSM beyond the per-bit latch. Two-register pipeline: src_d, then pending.

Optional Feature:
Macro IRQ_CTRL_ID_EN.
- Defined: offset 0x10 reads ID = index+1 of the lowest-numbered set bit of hw_int, or 0 if none. Purely combinational, read-only; writes to 0x10 are ignored.
- Undefined: 0x10 reads 0; no priority encoder is built.

Test Plan:
1. Reset, then read PENDING/MASK/MODE -> all 0x0. hw_int=0 and irq=0, even with src_irq=6'b111111 in level mode and mask 0.
2. MASK=0x1, MODE=0; drive src_irq[0]=1 for 3 cycles then 0 -> hw_int[0]=1 for the 3 cycles following, each 1 cycle late. It drops 1 cycle after src falls. W1C to PENDING has no effect.
3. MASK=0x1, MODE=0x1; one-cycle pulse on src_irq[0] -> PENDING reads 0x1 and hw_int[0]=1 persistently. Writing 0x1 to PENDING clears it on the next cycle.
4. Edge mode, src_irq[2] rises on the same cycle a W1C 0x4 is written -> PENDING bit 2 remains 1.
5. MODE=0x2, mask 0, pulse src_irq[1] -> PENDING=0x2, hw_int=0. Write MASK=0x2 -> hw_int=0x02 next cycle. Write MODE=0x0 -> PENDING bit 1 cleared.
6. IRQ_CTRL_ID_EN defined, mask 0x3F, edge mode, pulse sources 3 and 5 -> ID reads 4. Clear bit 3 -> ID reads 6. Clear all -> 0. Apply rst=0 with pending set -> all cleared next cycle.
